// File: rtl/bitmask_serializer_if.sv
// Handshake bundle for bitmask_serializer: a mask input channel, an index
// output channel and a busy flag. The serializer binds to the slave modport.
// Whatever feeds masks and consumes beats binds to the master modport.
interface bitmask_serializer_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  // Mask input channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bitmask;

  // Index output channel
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;

  // Status
  logic             busy;

  modport slave (
    input  in_valid,
    input  in_bitmask,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_zero,
    output busy
  );

  modport master (
    output in_valid,
    output in_bitmask,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_zero,
    input  busy
  );
endinterface

// File: rtl/bitmask_serializer.sv
// bitmask_serializer: takes one WIDTH-bit essential-bit mask per handshake.
// It emits the MSB-relative position of each set bit, one per output beat,
// and flags the final beat. An all-zero mask produces one dummy beat with
// out_zero set.
//
// Position encoding: mask bit WIDTH-1 reports index 0 and mask bit 0 reports
// index WIDTH-1. This holds in both scan orders.
// LSB_FIRST selects the order in which the set bits are visited.
module bitmask_serializer #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  bitmask_serializer_if.slave   bus
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_residue;
  logic [WIDTH-1:0] w_residue_next;
  logic             r_zero;
  logic             w_zero_next;

  // Encoder outputs: one-hot of the bit being reported and its raw position.
  logic [WIDTH-1:0] w_sel;
  logic [IDX_W-1:0] w_pos;

  logic             w_scan;
  logic             w_single;
  logic             w_last;
  logic             w_beat;
  logic             w_in_ready;
  logic             w_accept;

  // The priority search picks the bit to report next. Only the registered
  // residue feeds it, so out_idx never depends on in_bitmask or out_ready.
  // Both variants let the last match in loop order win. The loop direction
  // therefore decides which end of the residue has priority.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      // Lowest set bit of the residue wins.
      always_comb begin
        w_sel = '0;
        w_pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (r_residue[i]) begin
            w_sel    = '0;
            w_sel[i] = 1'b1;
            w_pos    = IDX_W'(i);
          end
        end
      end
    end else begin : g_msb_first
      // Highest set bit of the residue wins.
      always_comb begin
        w_sel = '0;
        w_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (r_residue[i]) begin
            w_sel    = '0;
            w_sel[i] = 1'b1;
            w_pos    = IDX_W'(i);
          end
        end
      end
    end
  endgenerate

  assign w_scan = (r_state == SCAN);

  // The residue holds at most one set bit when clearing its lowest set bit
  // leaves nothing behind. This also covers the all-zero residue of a zero
  // mask.
  assign w_single = ((r_residue & (r_residue - WIDTH'(1))) == '0);

  // Outputs are gated by SCAN so that they all read 0 while idle and after
  // reset.
  assign w_last     = w_scan && (r_zero || w_single);
  assign w_beat     = w_scan && bus.out_ready;

  // Accept while idle, or in the same cycle as the final beat is taken.
  // This lets the next mask follow with no bubble.
  assign w_in_ready = (r_state == IDLE) || (w_beat && w_last);
  assign w_accept   = bus.in_valid && w_in_ready;

  // WIDTH is a power of two, so WIDTH-1-p is the bitwise complement of p.
  assign bus.out_idx   = (w_scan && !r_zero) ? ~w_pos : '0;
  assign bus.out_valid = w_scan;
  assign bus.out_last  = w_last;
  assign bus.out_zero  = w_scan && r_zero;
  assign bus.busy      = w_scan;
  assign bus.in_ready  = w_in_ready;

  // Next-state logic: consume a beat, drop back to idle on the last beat,
  // and let a concurrent accept override both.
  always_comb begin
    w_state_next   = r_state;
    w_residue_next = r_residue;
    w_zero_next    = r_zero;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next   = SCAN;
          w_residue_next = bus.in_bitmask;
          w_zero_next    = (bus.in_bitmask == '0);
        end
      end
      SCAN: begin
        if (w_beat) begin
          w_residue_next = r_residue & ~w_sel;
          if (w_last) begin
            w_state_next = IDLE;
            w_zero_next  = 1'b0;
          end
        end
        if (w_accept) begin
          w_state_next   = SCAN;
          w_residue_next = bus.in_bitmask;
          w_zero_next    = (bus.in_bitmask == '0);
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_residue_next = '0;
        w_zero_next    = 1'b0;
      end
    endcase
  end

  // State, residue and zero flag registers. Reset discards any held mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_residue <= '0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_residue <= w_residue_next;
      r_zero    <= w_zero_next;
    end
  end

endmodule

// File: tb/tb_bitmask_serializer.sv
// Directed testbench for bitmask_serializer.
// It covers three instances: WIDTH=16 MSB-first, WIDTH=16 LSB-first and
// WIDTH=64 MSB-first. Inputs change just after the falling edge. Outputs are
// checked 1 ns later, well before the next rising edge.
module tb_bitmask_serializer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bitmask_serializer_if #(.WIDTH(16)) if16m ();
  bitmask_serializer_if #(.WIDTH(16)) if16l ();
  bitmask_serializer_if #(.WIDTH(64)) if64  ();

  bitmask_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_dut16m (
    .clk   (clk),
    .reset (reset),
    .bus   (if16m)
  );

  bitmask_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) u_dut16l (
    .clk   (clk),
    .reset (reset),
    .bus   (if16l)
  );

  bitmask_serializer #(.WIDTH(64), .LSB_FIRST(1'b0)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic beat_m(input string tag, input int idx, input bit last, input bit zero, input bit rdy);
    $display("[TB] %s: w16 msb valid=%0b idx=%0d last=%0b zero=%0b in_ready=%0b",
             tag, if16m.out_valid, if16m.out_idx, if16m.out_last, if16m.out_zero, if16m.in_ready);
    chk({tag, ".valid"}, 64'(if16m.out_valid), 64'd1);
    chk({tag, ".idx"},   64'(if16m.out_idx),   64'(idx));
    chk({tag, ".last"},  64'(if16m.out_last),  64'(last));
    chk({tag, ".zero"},  64'(if16m.out_zero),  64'(zero));
    chk({tag, ".rdy"},   64'(if16m.in_ready),  64'(rdy));
  endtask

  task automatic beat_l(input string tag, input int idx, input bit last, input bit rdy);
    $display("[TB] %s: w16 lsb valid=%0b idx=%0d last=%0b in_ready=%0b",
             tag, if16l.out_valid, if16l.out_idx, if16l.out_last, if16l.in_ready);
    chk({tag, ".valid"}, 64'(if16l.out_valid), 64'd1);
    chk({tag, ".idx"},   64'(if16l.out_idx),   64'(idx));
    chk({tag, ".last"},  64'(if16l.out_last),  64'(last));
    chk({tag, ".rdy"},   64'(if16l.in_ready),  64'(rdy));
  endtask

  task automatic idle_m(input string tag);
    $display("[TB] %s: w16 msb valid=%0b busy=%0b in_ready=%0b",
             tag, if16m.out_valid, if16m.busy, if16m.in_ready);
    chk({tag, ".valid"}, 64'(if16m.out_valid), 64'd0);
    chk({tag, ".busy"},  64'(if16m.busy),      64'd0);
    chk({tag, ".rdy"},   64'(if16m.in_ready),  64'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    if16m.in_valid = 1'b0; if16m.in_bitmask = '0; if16m.out_ready = 1'b0;
    if16l.in_valid = 1'b0; if16l.in_bitmask = '0; if16l.out_ready = 1'b0;
    if64.in_valid  = 1'b0; if64.in_bitmask  = '0; if64.out_ready  = 1'b0;

    // Reset state on all instances
    repeat (3) tick();
    reset = 1'b0;
    tick();
    $display("[TB] reset: checking idle outputs");
    chk("rst.valid",  64'(if16m.out_valid), 64'd0);
    chk("rst.busy",   64'(if16m.busy),      64'd0);
    chk("rst.idx",    64'(if16m.out_idx),   64'd0);
    chk("rst.last",   64'(if16m.out_last),  64'd0);
    chk("rst.zero",   64'(if16m.out_zero),  64'd0);
    chk("rst.rdy",    64'(if16m.in_ready),  64'd1);
    chk("rst.l.rdy",  64'(if16l.in_ready),  64'd1);
    chk("rst.w.rdy",  64'(if64.in_ready),   64'd1);
    chk("rst.w.last", 64'(if64.out_last),   64'd0);

    // 16'h8001, MSB-first
    if16m.in_valid = 1'b1; if16m.in_bitmask = 16'h8001; if16m.out_ready = 1'b1;
    #1 chk("m8001.acc_rdy", 64'(if16m.in_ready), 64'd1);
    tick();
    if16m.in_valid = 1'b0;
    #1 beat_m("m8001.b1", 0, 1'b0, 1'b0, 1'b0);
    tick();
    beat_m("m8001.b2", 15, 1'b1, 1'b0, 1'b1);
    tick();
    idle_m("m8001.after");

    // 16'h8001, LSB-first
    if16l.in_valid = 1'b1; if16l.in_bitmask = 16'h8001; if16l.out_ready = 1'b1;
    tick();
    if16l.in_valid = 1'b0;
    #1 beat_l("l8001.b1", 15, 1'b0, 1'b0);
    tick();
    beat_l("l8001.b2", 0, 1'b1, 1'b1);
    tick();
    chk("l8001.after.valid", 64'(if16l.out_valid), 64'd0);

    // All-zero mask: one dummy beat
    if16m.in_valid = 1'b1; if16m.in_bitmask = 16'h0000; if16m.out_ready = 1'b1;
    tick();
    if16m.in_valid = 1'b0;
    #1 beat_m("zero.b1", 0, 1'b1, 1'b1, 1'b1);
    tick();
    idle_m("zero.after");
    chk("zero.after.zero", 64'(if16m.out_zero), 64'd0);

    // All-ones mask with alternating stall/accept; in_valid held high with a
    // decoy mask while busy must be ignored
    if16m.in_valid = 1'b1; if16m.in_bitmask = 16'hFFFF; if16m.out_ready = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      if16m.in_valid   = (k < 15);
      if16m.in_bitmask = 16'h1234;
      if16m.out_ready  = 1'b0;
      #1 beat_m($sformatf("ffff.stall%0d", k), k, (k == 15), 1'b0, 1'b0);
      tick();
      if16m.out_ready = 1'b1;
      #1 beat_m($sformatf("ffff.take%0d", k), k, (k == 15), 1'b0, (k == 15));
      tick();
    end
    idle_m("ffff.after");

    // Back-to-back masks with no bubble
    if16m.in_valid = 1'b1; if16m.in_bitmask = 16'h0410; if16m.out_ready = 1'b1;
    tick();
    if16m.in_bitmask = 16'h0002;
    #1 beat_m("b2b.b1", 5, 1'b0, 1'b0, 1'b0);
    tick();
    beat_m("b2b.b2", 11, 1'b1, 1'b0, 1'b1);
    tick();
    if16m.in_valid = 1'b0;
    #1 beat_m("b2b.b3", 14, 1'b1, 1'b0, 1'b1);
    tick();
    idle_m("b2b.after");

    // Reset mid-scan on WIDTH=16 and WIDTH=64
    if16m.in_valid = 1'b1; if16m.in_bitmask = 16'h00F0; if16m.out_ready = 1'b1;
    if64.in_valid  = 1'b1; if64.in_bitmask  = 64'h00F0; if64.out_ready  = 1'b1;
    tick();
    if16m.in_valid = 1'b0;
    if64.in_valid  = 1'b0;
    #1 beat_m("rmid.b1", 8, 1'b0, 1'b0, 1'b0);
    chk("rmid.w.idx", 64'(if64.out_idx), 64'd56);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 idle_m("rmid.post");
    chk("rmid.post.idx",  64'(if16m.out_idx),  64'd0);
    chk("rmid.post.last", 64'(if16m.out_last), 64'd0);
    chk("rmid.w.valid",   64'(if64.out_valid), 64'd0);
    chk("rmid.w.busy",    64'(if64.busy),      64'd0);
    chk("rmid.w.rdy",     64'(if64.in_ready),  64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("[TB] rmid.stale%0d: w16 valid=%0b w64 valid=%0b", k, if16m.out_valid, if64.out_valid);
      chk($sformatf("rmid.stale%0d", k),   64'(if16m.out_valid), 64'd0);
      chk($sformatf("rmid.w.stale%0d", k), 64'(if64.out_valid),  64'd0);
    end

    // WIDTH=64, mask 64'h1: a single beat at index 63
    if64.in_valid = 1'b1; if64.in_bitmask = 64'h1; if64.out_ready = 1'b1;
    tick();
    if64.in_valid = 1'b0;
    #1 $display("[TB] w64.b1: valid=%0b idx=%0d last=%0b zero=%0b",
                if64.out_valid, if64.out_idx, if64.out_last, if64.out_zero);
    chk("w64.b1.valid", 64'(if64.out_valid), 64'd1);
    chk("w64.b1.idx",   64'(if64.out_idx),   64'd63);
    chk("w64.b1.last",  64'(if64.out_last),  64'd1);
    chk("w64.b1.zero",  64'(if64.out_zero),  64'd0);
    tick();
    chk("w64.after.valid", 64'(if64.out_valid), 64'd0);
    chk("w64.after.busy",  64'(if64.busy),      64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitmask_serializer.md
Name: bitmask_serializer

Overview:
- Sequential, parametrised successor to the 16-to-4 leading-one priority encoder used by the bit-serial PE datapath.
- Accepts one WIDTH-bit essential-bit mask per handshake.
- Emits the position of every set bit, one per output beat, then signals last. The PE uses this to skip zero bits.
- Scan direction is selectable. Position encoding is MSB-relative, as in the existing encoder: mask bit WIDTH-1 reports index 0, mask bit 0 reports index WIDTH-1.

Parameters:
- WIDTH, 16, mask width; power of two, 4 to 64.
- IDX_W, $clog2(WIDTH), width of out_idx; derived, not overridden.
- LSB_FIRST, 0, scan order. 0 = highest set bit first; 1 = lowest set bit first. Index encoding stays MSB-relative in both modes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bitmask is valid.
- in_ready  out  1  block can accept a mask this cycle.
- in_bitmask  in  WIDTH  mask to serialise.
- out_valid  out  1  out_idx, out_last and out_zero are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_idx  out  IDX_W  MSB-relative position of the current set bit.
- out_last  out  1  current beat is the final beat of this mask.
- out_zero  out  1  mask was all-zero; single dummy beat.
- busy  out  1  a mask is held (state SCAN).

Behaviour:
- State: 2-state FSM {IDLE, SCAN}, plus a WIDTH-bit residue register and a zero flag register.
- Reset (synchronous, active-high):
  - state=IDLE, residue=0, zero flag=0.
  - Outputs: out_valid=0, busy=0, out_idx=0, out_last=0, out_zero=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset asserted mid-SCAN discards the held mask; no further beats are emitted.
- Accept: in_valid && in_ready.
  - residue <= in_bitmask; zero flag <= (in_bitmask==0); state <= SCAN.
  - Latency: first beat is presented (out_valid=1) the cycle after accept.
- Output logic: out_valid = (state==SCAN).
  - out_idx is combinational from the registered residue only. It is never combinational from in_bitmask or out_ready.
  - LSB_FIRST=0: out_idx = WIDTH-1-p, where p is the highest set bit of residue.
  - LSB_FIRST=1: p is the lowest set bit of residue.
  - out_last = residue has at most one set bit.
  - out_zero = zero flag. When zero flag=1: out_idx=0, out_last=1.
- Beat handshake: out_valid && out_ready.
  - Clears bit p in residue.
  - If out_last, state <= IDLE, unless a new mask is accepted in the same cycle.
- Backpressure: while out_valid && !out_ready, out_idx, out_last and out_zero hold stable. The residue does not change.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). The last-beat term is combinational through out_ready.
  - This gives back-to-back masks with no bubble.
  - On a simultaneous last-beat handshake and accept, the new mask loads and state stays SCAN.
- in_valid in SCAN, other than on the last-beat cycle, is ignored. No mask is accepted or lost while busy.
- Beat count:
  - Beats per mask = popcount(in_bitmask) for a nonzero mask; 1 for a zero mask.
  - Maximum is WIDTH beats (all-ones mask); the residue reaches 0 exactly on the last beat.
- Encoder: implementation choice, e.g. a for-loop priority search. Synthesisable and parametric; no casez tables tied to a width.
- in_bitmask and in_valid are don't-care while in_ready=0.

Test Plan:
- WIDTH=16, LSB_FIRST=0; reset, then accept 16'h8001 with out_ready=1.
  - Beat 1: out_idx=0, out_last=0.
  - Beat 2: out_idx=15, out_last=1.
  - in_ready=1 on beat 2; busy=0 afterwards.
- Same mask 16'h8001 with LSB_FIRST=1: beats out_idx=15 then 0; last on the second beat.
- Accept 16'h0000: exactly one beat, out_zero=1, out_idx=0, out_last=1; then IDLE.
- Accept 16'hFFFF with out_ready toggling 1,0,1,0,...
  - 16 beats, out_idx=0..15 in order; outputs stable during every stall.
  - in_ready=0 until the last handshake.
- Back-to-back: hold in_valid=1 with masks 16'h0410 then 16'h0002, out_ready=1.
  - Beats idx 5, 11 (last), then 14 (last); no idle cycle between masks.
- Accept 16'h00F0; after one beat, assert reset for 1 cycle.
  - Next cycle: out_valid=0, busy=0, in_ready=1; no stale beats afterwards.
  - Repeat at WIDTH=64 with mask 64'h1 → single beat out_idx=63, out_last=1.
